// File: rtl/fifo_if_pkg.sv
// Shared definitions for the FIFO write-side lane packing path.
// Holds width derivations and status counter defaults used by the packer.
package fifo_if_pkg;

    localparam int unsigned CNT_WIDTH_DEF = 32;

    function automatic int unsigned base_width(input int unsigned if_width,
                                               input int unsigned divisor);
        return if_width / divisor;
    endfunction

    // Lane counter width; at least one bit so a single-lane config still elaborates.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_hold_reg.sv
// One-entry hold register in front of the FIFO write port.
// Keeps a completed word stable while the FIFO is full; a load in the write cycle keeps it valid.
module fifo_wr_hold_reg #(
    parameter int unsigned WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_padded,
    input  logic             fifo_full,
    output logic [WIDTH-1:0] hold_data,
    output logic             wren,
    output logic             hold_vld,
    output logic             padded
);

    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic             padded_q, padded_d;

    assign wren      = hold_vld_q & ~fifo_full & ~rst;
    assign hold_data = hold_q;
    assign hold_vld  = hold_vld_q;
    assign padded    = padded_q;

    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q & ~wren;
        padded_d   = padded_q;
        if (load) begin
            hold_d     = load_data;
            hold_vld_d = 1'b1;
            padded_d   = load_padded;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            padded_q   <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            padded_q   <= padded_d;
        end
    end

endmodule

// File: rtl/fifo_wr_lane_packer.sv
// Packs BASE_WIDTH-bit beats into IF_WIDTH-bit FIFO words, first beat in lane 0.
// s_last closes a short word early; lanes above the closing beat are filled with PAD_VALUE.
module fifo_wr_lane_packer
    import fifo_if_pkg::*;
#(
    parameter int unsigned                  IF_WIDTH       = 256,
    parameter int unsigned                  DIVISOR        = 8,
    parameter logic [IF_WIDTH/DIVISOR-1:0]  PAD_VALUE      = '0,
    parameter bit                           AFULL_THROTTLE = 1'b0,
    parameter int unsigned                  CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IF_WIDTH/DIVISOR-1:0] s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [IF_WIDTH-1:0]         fifo_wrdata,
    output logic                        fifo_wren,
    input  logic                        fifo_full,
    input  logic                        fifo_almostfull,
    output logic [CNT_WIDTH-1:0]        word_cnt,
    output logic [CNT_WIDTH-1:0]        partial_cnt,
    output logic                        busy
);

    localparam int unsigned       BASE_WIDTH = base_width(IF_WIDTH, DIVISOR);
    localparam int unsigned       LANE_W     = clog2_min1(DIVISOR);
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(DIVISOR - 1);

    logic [LANE_W-1:0]    lane_cnt_q, lane_cnt_d;
    logic [IF_WIDTH-1:0]  asm_q, asm_d;
    logic [IF_WIDTH-1:0]  word_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0] partial_cnt_q, partial_cnt_d;
    logic                 accept, complete;
    logic                 hold_vld, hold_padded, wren;
    logic [31:0]          lane_u;

    assign s_ready  = ~rst & (~hold_vld | ~fifo_full) & ~(AFULL_THROTTLE & fifo_almostfull);
    assign accept   = s_valid & s_ready;
    assign complete = accept & (s_last | (lane_cnt_q == LAST_LANE));
    assign lane_u   = 32'(lane_cnt_q);

    always_comb begin
        lane_cnt_d = lane_cnt_q;
        asm_d      = asm_q;
        if (accept) begin
            asm_d[lane_u*BASE_WIDTH +: BASE_WIDTH] = s_data;
            lane_cnt_d = complete ? '0 : lane_cnt_q + LANE_W'(1);
        end
    end

    // Word handed to the hold register: filled lanes, the closing beat, then padding.
    always_comb begin
        word_d = '0;
        for (int unsigned i = 0; i < DIVISOR; i++) begin
            if (i < lane_u) begin
                word_d[i*BASE_WIDTH +: BASE_WIDTH] = asm_q[i*BASE_WIDTH +: BASE_WIDTH];
            end else if (i == lane_u) begin
                word_d[i*BASE_WIDTH +: BASE_WIDTH] = s_data;
            end else begin
                word_d[i*BASE_WIDTH +: BASE_WIDTH] = PAD_VALUE;
            end
        end
    end

    always_comb begin
        word_cnt_d    = word_cnt_q + CNT_WIDTH'(wren);
        partial_cnt_d = partial_cnt_q + CNT_WIDTH'(wren & hold_padded);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_cnt_q    <= '0;
            asm_q         <= '0;
            word_cnt_q    <= '0;
            partial_cnt_q <= '0;
        end else begin
            lane_cnt_q    <= lane_cnt_d;
            asm_q         <= asm_d;
            word_cnt_q    <= word_cnt_d;
            partial_cnt_q <= partial_cnt_d;
        end
    end

    fifo_wr_hold_reg #(
        .WIDTH (IF_WIDTH)
    ) u_hold (
        .clk         (clk),
        .rst         (rst),
        .load        (complete),
        .load_data   (word_d),
        .load_padded (lane_cnt_q != LAST_LANE),
        .fifo_full   (fifo_full),
        .hold_data   (fifo_wrdata),
        .wren        (wren),
        .hold_vld    (hold_vld),
        .padded      (hold_padded)
    );

    assign fifo_wren   = wren;
    assign word_cnt    = word_cnt_q;
    assign partial_cnt = partial_cnt_q;
    assign busy        = ~rst & ((lane_cnt_q != '0) | hold_vld);

endmodule

// File: tb/tb_fifo_wr_lane_packer.sv
// Bench for fifo_wr_lane_packer at IF_WIDTH=32, DIVISOR=4, PAD_VALUE=0, AFULL_THROTTLE=1.
// Directed table, hand sequences for full/reset corners, then random traffic against a word scoreboard.
module tb_fifo_wr_lane_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid, s_last, s_ready;
    logic [31:0] fifo_wrdata;
    logic        fifo_wren, fifo_full, fifo_almostfull;
    logic [31:0] word_cnt, partial_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_wr_lane_packer #(
        .IF_WIDTH       (32),
        .DIVISOR        (4),
        .PAD_VALUE      (8'h00),
        .AFULL_THROTTLE (1'b1),
        .CNT_WIDTH      (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_last          (s_last),
        .s_ready         (s_ready),
        .fifo_wrdata     (fifo_wrdata),
        .fifo_wren       (fifo_wren),
        .fifo_full       (fifo_full),
        .fifo_almostfull (fifo_almostfull),
        .word_cnt        (word_cnt),
        .partial_cnt     (partial_cnt),
        .busy            (busy)
    );

    typedef struct {
        logic        v, l, f, a;
        logic [7:0]  d;
        logic        e_ready, e_wren;
        logic [31:0] e_data, e_wc, e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        pad;
    } word_t;

    vec_t        tbl[$];
    word_t       exp_q[$];
    logic [7:0]  cur[$];
    logic [31:0] m_wc, m_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic r, input logic v, input logic l, input logic [7:0] d,
                         input logic f, input logic a);
        @(negedge clk);
        rst = r; s_valid = v; s_last = l; s_data = d; fifo_full = f; fifo_almostfull = a;
        #1;
    endtask

    // Scoreboard cycle: a word is held iff one is completed but not yet written.
    task automatic rand_cycle(input logic v, input logic l, input logic [7:0] d,
                              input logic f, input logic a, output logic acc);
        logic        m_ready, m_wren;
        logic [31:0] w;
        drive(1'b0, v, l, d, f, a);
        m_ready = (exp_q.size() == 0 || !f) && !a;
        m_wren  = (exp_q.size() != 0) && !f;
        check("rnd_ready", s_ready, m_ready);
        check("rnd_wren", fifo_wren, m_wren);
        if (exp_q.size() != 0) check("rnd_wrdata", fifo_wrdata, exp_q[0].data);
        check("rnd_word_cnt", word_cnt, m_wc);
        check("rnd_partial_cnt", partial_cnt, m_pc);
        if (m_wren) begin
            m_wc = m_wc + 1;
            if (exp_q[0].pad) m_pc = m_pc + 1;
            void'(exp_q.pop_front());
        end
        acc = v && m_ready;
        if (acc) begin
            cur.push_back(d);
            if (cur.size() == 4 || l) begin
                w = '0;
                for (int i = 0; i < 4; i++) w[i*8 +: 8] = (i < cur.size()) ? cur[i] : 8'h00;
                exp_q.push_back(word_t'{w, cur.size() < 4});
                cur.delete();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   wren_seen;
        int   accepted;
        int   cyc;
        logic acc;

        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        fifo_full = 1'b0; fifo_almostfull = 1'b0;

        // Reset state
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
            check("rst_ready", s_ready, 1'b0);
            check("rst_wren", fifo_wren, 1'b0);
            check("rst_busy", busy, 1'b0);
        end

        //                 v     l     f     a     d      rdy   wren  data          wc  pc
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 32'h00000000, 0, 0});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 32'h00000000, 0, 0});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 32'h00000000, 0, 0});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h44, 1'b1, 1'b0, 32'h00000000, 0, 0});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h44332211, 0, 0});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h44332211, 1, 0});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b0, 32'h44332211, 1, 0});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 8'hBB, 1'b1, 1'b0, 32'h44332211, 1, 0});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h0000BBAA, 1, 0});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0000BBAA, 2, 1});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 32'h0000BBAA, 2, 1});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b1, 8'h78, 1'b0, 1'b0, 32'h0000BBAA, 2, 1});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h71, 1'b1, 1'b0, 32'h0000BBAA, 2, 1});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h72, 1'b1, 1'b0, 32'h0000BBAA, 2, 1});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h73, 1'b1, 1'b0, 32'h0000BBAA, 2, 1});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h74, 1'b1, 1'b0, 32'h0000BBAA, 2, 1});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h74737271, 2, 1});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0, 32'h74737271, 3, 1});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h82, 1'b1, 1'b0, 32'h74737271, 3, 1});
        tbl.push_back(vec_t'{1'b1, 1'b0, 1'b0, 1'b0, 8'h83, 1'b1, 1'b0, 32'h74737271, 3, 1});
        tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 1'b0, 8'h84, 1'b1, 1'b0, 32'h74737271, 3, 1});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 32'h84838281, 3, 1});
        tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h84838281, 4, 1});

        foreach (tbl[i]) begin
            drive(1'b0, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].f, tbl[i].a);
            check($sformatf("vec%0d_ready", i), s_ready, tbl[i].e_ready);
            check($sformatf("vec%0d_wren", i), fifo_wren, tbl[i].e_wren);
            check($sformatf("vec%0d_wrdata", i), fifo_wrdata, tbl[i].e_data);
            check($sformatf("vec%0d_word_cnt", i), word_cnt, tbl[i].e_wc);
            check($sformatf("vec%0d_partial_cnt", i), partial_cnt, tbl[i].e_pc);
        end

        // FIFO full: first word held stable, upstream stalled, then both words drain in order.
        wren_seen = 0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(i), 1'b1, 1'b0);
            check("full_fill_ready", s_ready, 1'b1);
            if (fifo_wren) wren_seen++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h05, 1'b1, 1'b0);
            check("full_stall_ready", s_ready, 1'b0);
            check("full_stall_wrdata", fifo_wrdata, 32'h04030201);
            check("full_stall_busy", busy, 1'b1);
            if (fifo_wren) wren_seen++;
        end
        drive(1'b0, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0);
        check("full_release_wren", fifo_wren, 1'b1);
        check("full_release_wrdata", fifo_wrdata, 32'h04030201);
        check("full_release_ready", s_ready, 1'b1);
        if (fifo_wren) wren_seen++;
        for (int i = 6; i <= 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
            check("full_refill_ready", s_ready, 1'b1);
            if (fifo_wren) wren_seen++;
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("full_second_wrdata", fifo_wrdata, 32'h08070605);
        if (fifo_wren) wren_seen++;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        if (fifo_wren) wren_seen++;
        check("full_wren_pulses", wren_seen, 2);
        check("full_word_cnt", word_cnt, 6);
        check("full_partial_cnt", partial_cnt, 1);

        // Reset mid-word discards the partial word.
        drive(1'b0, 1'b1, 1'b0, 8'h91, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 8'h92, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h93, 1'b0, 1'b0);
        check("rst_mid_ready", s_ready, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_mid_word_cnt", word_cnt, 0);
        check("rst_mid_partial_cnt", partial_cnt, 0);
        check("rst_mid_wrdata", fifo_wrdata, 32'h0);
        check("rst_mid_busy_after", busy, 1'b0);

        // Reset while a word is held behind a full FIFO; full releases during reset.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 8'hC1 + 8'(i), 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("rst_hold_busy", busy, 1'b1);
        check("rst_hold_wrdata", fifo_wrdata, 32'hC4C3C2C1);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_hold_wren", fifo_wren, 1'b0);
        check("rst_hold_busy_in_rst", busy, 1'b0);
        wren_seen = 0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        if (fifo_wren) wren_seen++;
        check("rst_hold_wrdata_after", fifo_wrdata, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h5A + 8'(i), 1'b0, 1'b0);
            if (fifo_wren) wren_seen++;
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_post_wrdata", fifo_wrdata, 32'h5D5C5B5A);
        if (fifo_wren) wren_seen++;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        if (fifo_wren) wren_seen++;
        check("rst_post_wren_pulses", wren_seen, 1);
        check("rst_post_word_cnt", word_cnt, 1);
        check("rst_post_partial_cnt", partial_cnt, 0);

        // Random traffic against the scoreboard.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        exp_q.delete(); cur.delete(); m_wc = 0; m_pc = 0;
        accepted = 0; cyc = 0;
        while (accepted < 400 && cyc < 6000) begin
            rand_cycle($urandom_range(0, 99) < 80, $urandom_range(0, 9) == 0, 8'($urandom),
                       $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10, acc);
            if (acc) accepted++;
            cyc++;
        end
        check("rnd_beats_accepted", accepted >= 400, 1'b1);
        for (int i = 0; i < 3; i++) rand_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        check("rnd_drained", exp_q.size(), 0);
        check("rnd_busy_idle", busy, cur.size() != 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
